// File: rtl/axi_cdc_drain_ctrl.sv
// Quiesce controller in front of an AXI CDC: counts outstanding bursts, drains them on request, then isolates.
// Latency: zero-cycle valid/ready gating (combinational from registered state); isolated_o one cycle after drain completes.
// Backpressure: a gate closes only between handshakes; a valid already presented downstream stays open until accepted.
module axi_cdc_drain_ctrl #(
  parameter int unsigned MaxTxn = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic isolate_req_i,
  output logic isolated_o,
  output logic busy_o,
  output logic unexp_rsp_o,
  input  logic slv_aw_valid_i,
  output logic slv_aw_ready_o,
  output logic mst_aw_valid_o,
  input  logic mst_aw_ready_i,
  input  logic slv_w_valid_i,
  input  logic slv_w_last_i,
  output logic slv_w_ready_o,
  output logic mst_w_valid_o,
  input  logic mst_w_ready_i,
  input  logic slv_ar_valid_i,
  output logic slv_ar_ready_o,
  output logic mst_ar_valid_o,
  input  logic mst_ar_ready_i,
  input  logic b_valid_i,
  input  logic b_ready_i,
  input  logic r_valid_i,
  input  logic r_ready_i,
  input  logic r_last_i
);

  localparam int CntW  = $clog2(MaxTxn + 1);
  localparam int CredW = CntW + 1;
  localparam logic [CntW-1:0]         MaxCnt  = CntW'(MaxTxn);
  localparam logic signed [CredW-1:0] CredMax = CredW'(MaxTxn);
  localparam logic signed [CredW-1:0] CredMin = -CredMax;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ISO} state_t;

  state_t                  state_q, state_d;
  logic [CntW-1:0]         wr_cnt_q, rd_cnt_q;
  // AW bursts issued minus W bursts completed; negative when W runs ahead of AW.
  logic signed [CredW-1:0] w_cred_q;
  logic                    aw_pend_q, w_pend_q, ar_pend_q;
  logic                    unexp_q;

  logic aw_gate, w_gate, ar_gate;
  logic aw_hs, w_hs, w_last_hs, ar_hs, b_hs, r_hs, r_last_hs, any_hs;
  logic cred_neg, cred_pos, cred_zero, drained;

  assign cred_neg  = w_cred_q[CredW-1];
  assign cred_zero = (w_cred_q == '0);
  assign cred_pos  = !cred_neg && !cred_zero;

  // A pending (offered but not accepted) valid keeps its gate open regardless of state.
  assign aw_gate = aw_pend_q
                 || (state_q == ST_RUN   && wr_cnt_q < MaxCnt && w_cred_q < CredMax)
                 || (state_q == ST_DRAIN && cred_neg && wr_cnt_q < MaxCnt);
  assign ar_gate = ar_pend_q || (state_q == ST_RUN && rd_cnt_q < MaxCnt);
  assign w_gate  = w_pend_q
                 || (state_q == ST_RUN   && w_cred_q > CredMin)
                 || (state_q == ST_DRAIN && cred_pos);

  assign mst_aw_valid_o = slv_aw_valid_i && aw_gate;
  assign slv_aw_ready_o = mst_aw_ready_i && aw_gate;
  assign mst_w_valid_o  = slv_w_valid_i  && w_gate;
  assign slv_w_ready_o  = mst_w_ready_i  && w_gate;
  assign mst_ar_valid_o = slv_ar_valid_i && ar_gate;
  assign slv_ar_ready_o = mst_ar_ready_i && ar_gate;

  assign aw_hs     = mst_aw_valid_o && mst_aw_ready_i;
  assign w_hs      = mst_w_valid_o  && mst_w_ready_i;
  assign w_last_hs = w_hs && slv_w_last_i;
  assign ar_hs     = mst_ar_valid_o && mst_ar_ready_i;
  assign b_hs      = b_valid_i && b_ready_i;
  assign r_hs      = r_valid_i && r_ready_i;
  assign r_last_hs = r_hs && r_last_i;
  assign any_hs    = aw_hs || w_hs || ar_hs || b_hs || r_hs;

  // With no counts, no pending valids and no handshake, every gate is shut and stays shut.
  assign drained = (wr_cnt_q == '0) && (rd_cnt_q == '0) && cred_zero
                && !aw_pend_q && !w_pend_q && !ar_pend_q && !any_hs;

  assign isolated_o  = (state_q == ST_ISO);
  assign busy_o      = (wr_cnt_q != '0) || (rd_cnt_q != '0) || !cred_zero;
  assign unexp_rsp_o = unexp_q;

  // Outstanding counters; a response at zero count is absorbed and flagged instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      w_cred_q <= '0;
      unexp_q  <= 1'b0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   wr_cnt_q <= wr_cnt_q + CntW'(1);
        2'b01:   if (wr_cnt_q != '0) wr_cnt_q <= wr_cnt_q - CntW'(1);
        default: wr_cnt_q <= wr_cnt_q;
      endcase
      case ({ar_hs, r_last_hs})
        2'b10:   rd_cnt_q <= rd_cnt_q + CntW'(1);
        2'b01:   if (rd_cnt_q != '0) rd_cnt_q <= rd_cnt_q - CntW'(1);
        default: rd_cnt_q <= rd_cnt_q;
      endcase
      case ({aw_hs, w_last_hs})
        2'b10:   w_cred_q <= w_cred_q + CredW'(1);
        2'b01:   w_cred_q <= w_cred_q - CredW'(1);
        default: w_cred_q <= w_cred_q;
      endcase
      unexp_q <= (b_hs && !aw_hs && wr_cnt_q == '0)
              || (r_last_hs && !ar_hs && rd_cnt_q == '0);
    end
  end

  // Remember valids presented downstream but not yet accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      ar_pend_q <= 1'b0;
    end else begin
      aw_pend_q <= mst_aw_valid_o && !mst_aw_ready_i;
      w_pend_q  <= mst_w_valid_o  && !mst_w_ready_i;
      ar_pend_q <= mst_ar_valid_o && !mst_ar_ready_i;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state: drain on request, abort back to RUN whenever the request drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (isolate_req_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!isolate_req_i) state_d = ST_RUN;
        else if (drained)   state_d = ST_ISO;
      end
      ST_ISO:   if (!isolate_req_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_axi_cdc_drain_ctrl.sv
// Bench for the AXI CDC drain controller: directed scenarios then randomized traffic.
// Expected outputs per cycle come from a transaction-count reference model and are queued.
// A negedge monitor pops each expectation and compares it against the DUT outputs.
module tb_axi_cdc_drain_ctrl;

  localparam int MAX = 8;
  localparam int RUN = 0, DRAIN = 1, ISO = 2;

  logic clk = 1'b0;
  logic rst;
  logic isolate_req_i, isolated_o, busy_o, unexp_rsp_o;
  logic slv_aw_valid_i, slv_aw_ready_o, mst_aw_valid_o, mst_aw_ready_i;
  logic slv_w_valid_i, slv_w_last_i, slv_w_ready_o, mst_w_valid_o, mst_w_ready_i;
  logic slv_ar_valid_i, slv_ar_ready_o, mst_ar_valid_o, mst_ar_ready_i;
  logic b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;

  always #5 clk = ~clk;

  axi_cdc_drain_ctrl #(.MaxTxn(MAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .isolate_req_i(isolate_req_i), .isolated_o(isolated_o), .busy_o(busy_o), .unexp_rsp_o(unexp_rsp_o),
    .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o),
    .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
    .slv_w_valid_i(slv_w_valid_i), .slv_w_last_i(slv_w_last_i), .slv_w_ready_o(slv_w_ready_o),
    .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
    .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
    .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
    .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i)
  );

  typedef struct packed {
    logic iso, busy, unexp, awv, awr, wv, wr, arv, arr;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: transaction counts and mode
  int m_wr, m_rd, m_wb, m_mode;
  bit m_awh, m_wh, m_arh, m_unexp;
  bit g_aw, g_w, g_ar;

  function automatic void model_reset();
    m_wr = 0; m_rd = 0; m_wb = 0; m_mode = RUN;
    m_awh = 0; m_wh = 0; m_arh = 0; m_unexp = 0;
  endfunction

  function automatic void dchk(input string name, input logic got, input logic want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, want %b", name, $time, got, want);
    end
  endfunction

  // Apply one cycle of inputs and queue the outputs the model predicts for it.
  task automatic drive(input bit req, input bit awv, input bit awrdy,
                       input bit wv, input bit wl, input bit wrdy,
                       input bit arv, input bit arrdy,
                       input bit bv, input bit br, input bit rv, input bit rr, input bit rl);
    obs_t e;
    isolate_req_i = req;
    slv_aw_valid_i = awv; mst_aw_ready_i = awrdy;
    slv_w_valid_i = wv; slv_w_last_i = wl; mst_w_ready_i = wrdy;
    slv_ar_valid_i = arv; mst_ar_ready_i = arrdy;
    b_valid_i = bv; b_ready_i = br;
    r_valid_i = rv; r_ready_i = rr; r_last_i = rl;
    // A channel may pass new traffic if an offer is outstanding, or if the mode permits it.
    g_aw = m_awh || (m_mode == RUN && m_wr < MAX && m_wb < MAX)
                 || (m_mode == DRAIN && m_wb < 0 && m_wr < MAX);
    g_ar = m_arh || (m_mode == RUN && m_rd < MAX);
    g_w  = m_wh  || (m_mode == RUN && m_wb > -MAX) || (m_mode == DRAIN && m_wb > 0);
    e.iso   = (m_mode == ISO);
    e.busy  = (m_wr != 0) || (m_rd != 0) || (m_wb != 0);
    e.unexp = m_unexp;
    e.awv = awv && g_aw; e.awr = awrdy && g_aw;
    e.wv  = wv && g_w;   e.wr  = wrdy && g_w;
    e.arv = arv && g_ar; e.arr = arrdy && g_ar;
    exp_q.push_back(e);
  endtask

  // Advance the model by the handshakes of the driven cycle, then move to the next cycle.
  task automatic tick();
    int aw_hs, w_hs, wl_hs, ar_hs, b_hs, r_hs, rl_hs, nwr, nrd;
    bit quiet;
    aw_hs = int'(slv_aw_valid_i && mst_aw_ready_i && g_aw);
    w_hs  = int'(slv_w_valid_i && mst_w_ready_i && g_w);
    wl_hs = int'(w_hs == 1 && slv_w_last_i);
    ar_hs = int'(slv_ar_valid_i && mst_ar_ready_i && g_ar);
    b_hs  = int'(b_valid_i && b_ready_i);
    r_hs  = int'(r_valid_i && r_ready_i);
    rl_hs = int'(r_hs == 1 && r_last_i);
    nwr = m_wr + aw_hs - b_hs;
    nrd = m_rd + ar_hs - rl_hs;
    quiet = (m_wr == 0) && (m_rd == 0) && (m_wb == 0) && !m_awh && !m_wh && !m_arh
         && (aw_hs + w_hs + ar_hs + b_hs + r_hs == 0);
    case (m_mode)
      RUN:   if (isolate_req_i) m_mode = DRAIN;
      DRAIN: if (!isolate_req_i) m_mode = RUN; else if (quiet) m_mode = ISO;
      default: if (!isolate_req_i) m_mode = RUN;
    endcase
    m_unexp = (nwr < 0) || (nrd < 0);
    m_wr = (nwr < 0) ? 0 : nwr;
    m_rd = (nrd < 0) ? 0 : nrd;
    m_wb = m_wb + aw_hs - wl_hs;
    m_awh = slv_aw_valid_i && g_aw && !mst_aw_ready_i;
    m_wh  = slv_w_valid_i && g_w && !mst_w_ready_i;
    m_arh = slv_ar_valid_i && g_ar && !mst_ar_ready_i;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit req, input int n);
    for (int i = 0; i < n; i++) begin
      drive(req, 0,0, 0,0,0, 0,0, 0,0,0,0,0);
      tick();
    end
  endtask

  // Monitor: compare every queued expectation against what the DUT shows
  always @(negedge clk) begin : monitor
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {isolated_o, busy_o, unexp_rsp_o, mst_aw_valid_o, slv_aw_ready_o,
           mst_w_valid_o, slv_w_ready_o, mst_ar_valid_o, slv_ar_ready_o};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs at %0t: got %b, want %b (iso,busy,unexp,awv,awr,wv,wr,arv,arr)",
                 $time, a, e);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit req, awv, wv, wl, arv, bv, rv;
    rst = 1'b1;
    isolate_req_i = 0; slv_aw_valid_i = 0; mst_aw_ready_i = 0;
    slv_w_valid_i = 0; slv_w_last_i = 0; mst_w_ready_i = 0;
    slv_ar_valid_i = 0; mst_ar_ready_i = 0;
    b_valid_i = 0; b_ready_i = 0; r_valid_i = 0; r_ready_i = 0; r_last_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    dchk("rst_isolated", isolated_o, 1'b0);
    dchk("rst_busy", busy_o, 1'b0);
    dchk("rst_unexp", unexp_rsp_o, 1'b0);
    rst = 1'b0;
    idle(0, 2);

    // 1: single AW, 4-beat W, B
    drive(0, 1,1, 0,0,0, 0,0, 0,0,0,0,0); tick();
    for (int b = 0; b < 4; b++) begin
      drive(0, 0,0, 1,(b == 3),1, 0,0, 0,0,0,0,0);
      #1; if (b == 0) dchk("s1_busy_inflight", busy_o, 1'b1);
      tick();
    end
    drive(0, 0,0, 0,0,0, 0,0, 1,1,0,0,0); #1; dchk("s1_busy_at_b", busy_o, 1'b1); tick();
    drive(0, 0,0, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s1_busy_after_b", busy_o, 1'b0); tick();

    // 2: AR limit
    for (int i = 0; i < MAX; i++) begin
      drive(0, 0,0, 0,0,0, 1,1, 0,0,0,0,0); tick();
    end
    drive(0, 0,0, 0,0,0, 1,1, 0,0,0,0,0); #1; dchk("s2_ar9_blocked", slv_ar_ready_o, 1'b0); tick();
    drive(0, 0,0, 0,0,0, 1,1, 0,0,1,1,1); #1; dchk("s2_ar9_blocked_rlast", slv_ar_ready_o, 1'b0); tick();
    drive(0, 0,0, 0,0,0, 1,1, 0,0,0,0,0); #1; dchk("s2_ar9_accepted", slv_ar_ready_o, 1'b1); tick();
    for (int i = 0; i < MAX; i++) begin
      drive(0, 0,0, 0,0,0, 0,0, 0,0,1,1,1); tick();
    end
    idle(0, 1);

    // 3: drain with 2 writes and 1 read outstanding
    drive(0, 1,1, 0,0,0, 1,1, 0,0,0,0,0); tick();
    drive(0, 1,1, 0,0,0, 0,0, 0,0,0,0,0); tick();
    idle(1, 1);
    drive(1, 1,1, 1,0,1, 1,1, 0,0,0,0,0); #1;
    dchk("s3_aw_blocked", mst_aw_valid_o, 1'b0);
    dchk("s3_ar_blocked", slv_ar_ready_o, 1'b0);
    dchk("s3_w_passes", mst_w_valid_o, 1'b1);
    tick();
    drive(1, 0,0, 1,1,1, 0,0, 0,0,0,0,0); tick();
    drive(1, 0,0, 1,0,1, 0,0, 0,0,0,0,0); tick();
    drive(1, 0,0, 1,1,1, 0,0, 0,0,0,0,0); tick();
    drive(1, 0,0, 0,0,0, 0,0, 0,0,1,1,1); tick();
    drive(1, 0,0, 0,0,0, 0,0, 1,1,0,0,0); tick();
    drive(1, 0,0, 0,0,0, 0,0, 1,1,0,0,0); #1; dchk("s3_iso_at_last_b", isolated_o, 1'b0); tick();
    drive(1, 0,0, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s3_iso_before", isolated_o, 1'b0); tick();
    drive(1, 0,0, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s3_iso_set", isolated_o, 1'b1); tick();
    drive(0, 0,0, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s3_iso_hold", isolated_o, 1'b1); tick();
    drive(0, 0,0, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s3_iso_clear", isolated_o, 1'b0); tick();

    // 4: AW held across the isolate request
    drive(1, 1,0, 0,0,0, 0,0, 0,0,0,0,0); tick();
    drive(1, 1,0, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s4_aw_sticky", mst_aw_valid_o, 1'b1); tick();
    drive(1, 1,1, 0,0,0, 0,0, 0,0,0,0,0); tick();
    drive(1, 0,0, 1,1,1, 0,0, 0,0,0,0,0); #1; dchk("s4_w_passes", mst_w_valid_o, 1'b1); tick();
    drive(1, 0,0, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s4_not_iso", isolated_o, 1'b0); tick();
    drive(1, 0,0, 0,0,0, 0,0, 1,1,0,0,0); tick();
    idle(1, 1);
    drive(1, 0,0, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s4_iso", isolated_o, 1'b1); tick();
    idle(0, 2);

    // 5: W ahead of AW, then isolate
    drive(0, 0,0, 1,1,1, 0,0, 0,0,0,0,0); tick();
    idle(1, 1);
    drive(1, 0,0, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s5_busy_neg", busy_o, 1'b1); tick();
    drive(1, 1,1, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s5_aw_in_drain", mst_aw_valid_o, 1'b1); tick();
    drive(1, 0,0, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s5_wait_b", isolated_o, 1'b0); tick();
    drive(1, 0,0, 0,0,0, 0,0, 1,1,0,0,0); tick();
    idle(1, 1);
    drive(1, 0,0, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s5_iso", isolated_o, 1'b1); tick();
    idle(0, 2);

    // 6: unexpected B, then an aborted drain
    drive(0, 0,0, 0,0,0, 0,0, 1,1,0,0,0); #1; dchk("s6_unexp_low", unexp_rsp_o, 1'b0); tick();
    drive(0, 0,0, 0,0,0, 0,0, 0,0,0,0,0); #1;
    dchk("s6_unexp_pulse", unexp_rsp_o, 1'b1);
    dchk("s6_wr_held_zero", busy_o, 1'b0);
    tick();
    drive(0, 0,0, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s6_unexp_end", unexp_rsp_o, 1'b0); tick();
    drive(0, 1,1, 0,0,0, 0,0, 0,0,0,0,0); tick();
    idle(1, 1);
    idle(0, 1);
    drive(0, 1,1, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s6_run_after_abort", mst_aw_valid_o, 1'b1); tick();
    drive(0, 0,0, 1,1,1, 0,0, 0,0,0,0,0); tick();
    drive(0, 0,0, 1,1,1, 0,0, 0,0,0,0,0); tick();
    drive(0, 0,0, 0,0,0, 0,0, 1,1,0,0,0); tick();
    drive(0, 0,0, 0,0,0, 0,0, 1,1,0,0,0); tick();
    drive(0, 0,0, 0,0,0, 0,0, 0,0,0,0,0); #1; dchk("s6_all_drained", busy_o, 1'b0); tick();

    // Randomized traffic; upstream valids stay up until accepted
    req = 0; awv = 0; wv = 0; wl = 0; arv = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) req = !req;
      if (!awv) awv = ($urandom_range(0, 9) < 4);
      if (!arv) arv = ($urandom_range(0, 9) < 4);
      if (!wv) begin
        wv = ($urandom_range(0, 9) < 5);
        wl = ($urandom_range(0, 2) == 0);
      end
      bv = (m_wr > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 29) == 0);
      rv = (m_rd > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 29) == 0);
      drive(req, awv, ($urandom_range(0, 9) < 7),
            wv, wl, ($urandom_range(0, 9) < 7),
            arv, ($urandom_range(0, 9) < 7),
            bv, ($urandom_range(0, 9) < 7), rv, ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 1) == 1));
      if (awv && g_aw && mst_aw_ready_i) awv = 0;
      if (wv && g_w && mst_w_ready_i) wv = 0;
      if (arv && g_ar && mst_ar_ready_i) arv = 0;
      tick();
    end
    idle(0, 2);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
